fetch_stage: RTL and testbench



---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus: req/gnt handshake, then rvalid/rdata,
// with at most one request outstanding.
interface fetch_stage_if #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches one instruction at a time into IF/ID,
// parks early responses while stalled and squashes in-flight fetches on redirect.
module fetch_stage #(
  parameter int              PC_W     = 64,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               prevent_update_pc,
  input  logic               prevent_update_reg_IF_ID,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  fetch_stage_if.master      imem,
  output logic [PC_W-1:0]    IF_ID_pc,
  output logic [INSTR_W-1:0] IF_ID_instr,
  output logic               IF_ID_valid
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] hold_q;
  logic [PC_W-1:0]    if_pc_q;
  logic [INSTR_W-1:0] if_instr_q;
  logic               if_valid_q;

  logic               stall;
  logic               deliver;
  logic [INSTR_W-1:0] deliver_word;
  logic [PC_W-1:0]    pc_inc_d;

  assign stall    = prevent_update_pc | prevent_update_reg_IF_ID;
  assign pc_inc_d = pc_q + PC_W'(PC_STEP);

  // A word reaches IF/ID either straight from memory or from the hold buffer.
  always_comb begin
    deliver      = 1'b0;
    deliver_word = '0;
    if (!redirect_valid && !stall) begin
      if (state_q == S_WAIT && imem.imem_rvalid) begin
        deliver      = 1'b1;
        deliver_word = imem.imem_rdata;
      end else if (state_q == S_HOLD) begin
        deliver      = 1'b1;
        deliver_word = hold_q;
      end
    end
  end

  assign imem.imem_req  = (state_q == S_FETCH) && arst_n;
  assign imem.imem_addr = pc_q;

  assign IF_ID_pc    = if_pc_q;
  assign IF_ID_instr = if_instr_q;
  assign IF_ID_valid = if_valid_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      hold_q     <= '0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
    end else if (redirect_valid) begin
      // Flush beats stall; any in-flight response becomes a DRAIN to be discarded.
      if_valid_q <= 1'b0;
      pc_q       <= redirect_pc;
      hold_q     <= '0;
      case (state_q)
        S_FETCH: state_q <= imem.imem_gnt    ? S_DRAIN : S_FETCH;
        S_WAIT:  state_q <= imem.imem_rvalid ? S_FETCH : S_DRAIN;
        S_HOLD:  state_q <= S_FETCH;
        S_DRAIN: state_q <= imem.imem_rvalid ? S_FETCH : S_DRAIN;
        default: state_q <= S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: if (imem.imem_gnt) state_q <= S_WAIT;
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (stall) begin
              hold_q  <= imem.imem_rdata;
              state_q <= S_HOLD;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_HOLD:  if (!stall) state_q <= S_FETCH;
        S_DRAIN: if (imem.imem_rvalid) state_q <= S_FETCH;
        default: state_q <= S_FETCH;
      endcase

      if (deliver) begin
        pc_q       <= pc_inc_d;
        if_pc_q    <= pc_q;
        if_instr_q <= deliver_word;
        if_valid_q <= 1'b1;
      end else if (!stall) begin
        if_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the stage.
module tb_fetch_stage;
  localparam int          PC_W    = 64;
  localparam int          INSTR_W = 32;
  localparam int          STEP    = 4;
  localparam logic [63:0] RST_PC  = 64'h0;

  logic        clk      = 1'b0;
  logic        arst_n   = 1'b1;
  logic        pu_pc    = 1'b0;
  logic        pu_reg   = 1'b0;
  logic        redir    = 1'b0;
  logic [63:0] redir_pc = 64'h0;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  fetch_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_stage #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RST_PC), .PC_STEP(STEP)
  ) dut (
    .clk                      (clk),
    .arst_n                   (arst_n),
    .prevent_update_pc        (pu_pc),
    .prevent_update_reg_IF_ID (pu_reg),
    .redirect_valid           (redir),
    .redirect_pc              (redir_pc),
    .imem                     (bus),
    .IF_ID_pc                 (if_pc),
    .IF_ID_instr              (if_instr),
    .IF_ID_valid              (if_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Memory responder state
  bit          gnt_v   = 1'b0;
  int          lat_v   = 0;
  bit          ovr_en  = 1'b0;
  logic [31:0] ovr_w   = 32'h0;
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_word;

  // Model: a PC, whether a fetch is in flight (and whether it was squashed),
  // an optional parked word, and the IF/ID contents.
  logic [63:0] m_pc;
  bit          m_out, m_sq, m_buf;
  logic [31:0] m_bufw;
  bit          m_valid;
  logic [63:0] m_ifpc;
  logic [31:0] m_ifinstr;

  function automatic logic [31:0] wfn(logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_out = 0; m_sq = 0; m_buf = 0; m_bufw = 0;
    m_valid = 0; m_ifpc = 0; m_ifinstr = 0;
    mem_busy = 0; mem_cnt = 0; mem_word = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    bit          stall, rv, got, acc, have;
    logic [31:0] w;
    if (!arst_n) begin
      model_reset();
      return;
    end
    stall = pu_pc | pu_reg;
    rv    = bus.imem_rvalid;
    got   = m_out && rv;
    acc   = !m_out && !m_buf && gnt_v;

    if (rv) mem_busy = 0;
    else if (mem_busy && mem_cnt > 0) mem_cnt--;
    if (acc) begin
      mem_busy = 1;
      mem_cnt  = lat_v;
      mem_word = ovr_en ? ovr_w : wfn(m_pc);
    end

    if (redir) begin
      m_valid = 0;
      if (acc) begin m_out = 1; m_sq = 1; end
      else if (got) begin m_out = 0; m_sq = 0; end
      else if (m_out) m_sq = 1;
      m_buf = 0;
      m_pc  = redir_pc;
    end else begin
      have = 0; w = 0;
      if (got) begin
        m_out = 0;
        if (!m_sq) begin have = 1; w = bus.imem_rdata; end
        m_sq = 0;
      end else if (m_buf) begin
        have = 1; w = m_bufw;
      end
      if (acc) begin m_out = 1; m_sq = 0; end
      if (have && !stall) begin
        m_ifpc = m_pc; m_ifinstr = w; m_valid = 1;
        m_pc = m_pc + 64'(STEP); m_buf = 0;
      end else if (have) begin
        m_buf = 1; m_bufw = w;
      end else if (!stall) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("imem_req", 64'(bus.imem_req), 64'(arst_n && !m_out && !m_buf));
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("IF_ID_valid", 64'(if_valid), 64'(m_valid));
    chk("IF_ID_pc", if_pc, m_ifpc);
    chk("IF_ID_instr", 64'(if_instr), 64'(m_ifinstr));
  endtask

  // Called at a falling edge: apply memory outputs, predict the edge, then check.
  task automatic tick();
    bus.imem_gnt    = gnt_v;
    bus.imem_rvalid = arst_n && mem_busy && (mem_cnt == 0);
    bus.imem_rdata  = bus.imem_rvalid ? mem_word : 32'($urandom());
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    model_reset();
    #1 arst_n = 1'b0;
    @(negedge clk);
    chk("rst_req", 64'(bus.imem_req), 64'h0);
    chk("rst_valid", 64'(if_valid), 64'h0);
    chk("rst_pc", if_pc, 64'h0);
    chk("rst_instr", 64'(if_instr), 64'h0);
    tick();

    // Back-to-back fetch
    arst_n = 1'b1; gnt_v = 1; lat_v = 0; ovr_en = 1; ovr_w = 32'h0000_0013;
    #1;
    chk("first_req", 64'(bus.imem_req), 64'h1);
    chk("first_addr", bus.imem_addr, 64'h0);
    tick();
    chk("wait_noreq", 64'(bus.imem_req), 64'h0);
    tick();
    chk("d0_valid", 64'(if_valid), 64'h1);
    chk("d0_pc", if_pc, 64'h0);
    chk("d0_instr", 64'(if_instr), 64'h13);
    chk("d0_next_addr", bus.imem_addr, 64'h4);
    tick(); tick();
    chk("d1_pc", if_pc, 64'h4);

    // Stall parks the response in the hold buffer
    ovr_w = 32'hDEAD_BEEF;
    tick();
    pu_reg = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_pc", if_pc, 64'h4);
      chk("stall_hold_instr", 64'(if_instr), 64'h13);
      chk("stall_noreq", 64'(bus.imem_req), 64'h0);
    end
    pu_reg = 0;
    tick();
    chk("unstall_instr", 64'(if_instr), 64'hDEAD_BEEF);
    chk("unstall_valid", 64'(if_valid), 64'h1);
    chk("unstall_pc", if_pc, 64'h8);
    chk("unstall_addr", bus.imem_addr, 64'hC);

    // Redirect while waiting: response must be discarded
    lat_v = 1; ovr_w = 32'h1111_1111;
    tick();
    redir = 1; redir_pc = 64'h100;
    tick();
    redir = 0;
    chk("redir_flush", 64'(if_valid), 64'h0);
    chk("redir_drain_noreq", 64'(bus.imem_req), 64'h0);
    tick();
    chk("redir_addr", bus.imem_addr, 64'h100);
    chk("redir_req", 64'(bus.imem_req), 64'h1);
    ovr_en = 0; lat_v = 0;
    tick(); tick();
    chk("redir_d_pc", if_pc, 64'h100);
    chk("redir_d_instr", 64'(if_instr), 64'(wfn(64'h100)));

    // Redirect together with stall while holding
    ovr_en = 1; ovr_w = 32'h2222_2222;
    tick();
    pu_pc = 1;
    tick();
    redir = 1; redir_pc = 64'h200;
    tick();
    chk("rs_flush", 64'(if_valid), 64'h0);
    chk("rs_addr", bus.imem_addr, 64'h200);
    chk("rs_req", 64'(bus.imem_req), 64'h1);
    redir = 0; pu_pc = 0; ovr_en = 0;
    tick(); tick();
    chk("rs_d_pc", if_pc, 64'h200);
    chk("rs_d_instr", 64'(if_instr), 64'(wfn(64'h200)));

    // PC wrap at the top of the address space
    gnt_v = 0; redir = 1; redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redir = 0; gnt_v = 1;
    tick(); tick();
    chk("wrap_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr", bus.imem_addr, 64'h0);

    // Asynchronous reset while a slow response is outstanding
    lat_v = 3;
    tick(); tick(); tick();
    arst_n = 0;
    model_reset();
    #1;
    chk("arst_req", 64'(bus.imem_req), 64'h0);
    chk("arst_valid", 64'(if_valid), 64'h0);
    chk("arst_pc", if_pc, 64'h0);
    chk("arst_instr", 64'(if_instr), 64'h0);
    chk("arst_addr", bus.imem_addr, RST_PC);
    tick(); tick();
    arst_n = 1;
    #1;
    chk("arst_rel_req", 64'(bus.imem_req), 64'h1);
    chk("arst_rel_addr", bus.imem_addr, RST_PC);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      gnt_v  = ($urandom_range(99) < 60);
      lat_v  = $urandom_range(3);
      pu_pc  = ($urandom_range(99) < 15);
      pu_reg = ($urandom_range(99) < 15);
      redir  = ($urandom_range(99) < 8);
      if ($urandom_range(3) == 0)
        redir_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(3) * 4);
      else
        redir_pc = {32'($urandom()), 32'($urandom())} & ~64'h3;
      arst_n = ($urandom_range(299) != 0);
      tick();
    end
    arst_n = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
